// File: rtl/vb_cpu_pkg.sv
// rtl/vb_cpu_pkg.sv - shared register indices, pair ids and IDU op encodings for the VerilogBoy core
package vb_cpu_pkg;

  // Byte register indices within one bank (default 8-register layout)
  localparam int REG_B   = 0;
  localparam int REG_C   = 1;
  localparam int REG_D   = 2;
  localparam int REG_E   = 3;
  localparam int REG_H   = 4;
  localparam int REG_L   = 5;
  localparam int REG_SPH = 6;
  localparam int REG_SPL = 7;

  // Pair ids: pair p covers byte registers {p,0} (high) and {p,1} (low)
  localparam int PAIR_BC = 0;
  localparam int PAIR_DE = 1;
  localparam int PAIR_HL = 2;
  localparam int PAIR_SP = 3;

  // Increment/decrement unit operations; the fourth code is reserved and behaves as none
  typedef enum logic [1:0] {
    IDU_NONE = 2'b00,
    IDU_INC  = 2'b01,
    IDU_DEC  = 2'b10,
    IDU_RSVD = 2'b11
  } idu_op_e;

endpackage

// File: rtl/regfile_idu.sv
// rtl/regfile_idu.sv - combinational pair increment/decrement unit
module regfile_idu
  import vb_cpu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         active
);

  // Step the operand by one with natural wrap; anything but inc/dec passes the value through
  always_comb begin
    dout   = din;
    active = 1'b0;
    case (op)
      IDU_INC: begin
        dout   = din + W'(1);
        active = 1'b1;
      end
      IDU_DEC: begin
        dout   = din - W'(1);
        active = 1'b1;
      end
      default: begin
        dout   = din;
        active = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port banked CPU register file with pair writes, IDU and bypass
module regfile_mp
  import vb_cpu_pkg::*;
#(
  parameter int             DW     = 8,
  parameter int             NREGS  = 8,
  parameter int             NRD    = 2,
  parameter int             BANKS  = 1,
  parameter int             BYPASS = 1,
  parameter logic [2*DW-1:0] SP_RST = '0,
  localparam int            AW     = $clog2(NREGS),
  localparam int            PW     = AW - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_sel,
  output logic [NRD*DW-1:0] rd_data,
  input  logic [PW-1:0]     rdw_sel,
  output logic [2*DW-1:0]   rdw_data,
  output logic [2*DW-1:0]   hl,
  output logic [2*DW-1:0]   sp,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_sel,
  input  logic [DW-1:0]     wr_data,
  input  logic              wrw_en,
  input  logic [PW-1:0]     wrw_sel,
  input  logic [2*DW-1:0]   wrw_data,
  input  logic [1:0]        idu_op,
  input  logic [PW-1:0]     idu_sel,
  output logic [2*DW-1:0]   idu_out,
  input  logic              bank_swap,
  output logic              bank
);

  localparam int NB      = BANKS * NREGS;
  localparam int MW      = $clog2(NB);
  localparam int SP_PAIR = NREGS / 2 - 1;

  logic [DW-1:0]   mem_q [NB];
  logic [DW-1:0]   mem_d [NB];
  logic            bank_q;
  logic            bank_d;
  logic [MW-1:0]   bank_off;
  logic [DW-1:0]   cur   [NREGS];
  logic [DW-1:0]   nxt   [NREGS];
  logic [DW-1:0]   view  [NREGS];
  logic [2*DW-1:0] idu_in;
  logic            idu_act;

  // Active-bank window: the IDU always steps the stored value, never a bypassed one
  always_comb begin
    bank_off = (BANKS == 2 && bank_q) ? MW'(NREGS) : '0;
    for (int i = 0; i < NREGS; i++) begin
      cur[i] = mem_q[bank_off + MW'(i)];
    end
    idu_in = {cur[{idu_sel, 1'b0}], cur[{idu_sel, 1'b1}]};
  end

  regfile_idu #(.W(2*DW)) u_idu (
    .op     (idu_op),
    .din    (idu_in),
    .dout   (idu_out),
    .active (idu_act)
  );

  // Per-byte next value, lowest priority applied first: IDU, then pair write, then byte write
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      nxt[i] = cur[i];
      if (idu_act && idu_sel == PW'(i / 2)) begin
        nxt[i] = (i % 2 == 0) ? idu_out[2*DW-1:DW] : idu_out[DW-1:0];
      end
      if (wrw_en && wrw_sel == PW'(i / 2)) begin
        nxt[i] = (i % 2 == 0) ? wrw_data[2*DW-1:DW] : wrw_data[DW-1:0];
      end
      if (wr_en && wr_sel == AW'(i)) begin
        nxt[i] = wr_data;
      end
      view[i] = (BYPASS != 0) ? nxt[i] : cur[i];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    assign rd_data[k*DW +: DW] = view[rd_sel[k*AW +: AW]];
  end

  assign rdw_data = {view[{rdw_sel, 1'b0}], view[{rdw_sel, 1'b1}]};
  assign hl       = {view[2*PAIR_HL], view[2*PAIR_HL+1]};
  assign sp       = {view[2*SP_PAIR], view[2*SP_PAIR+1]};
  assign bank     = bank_q;

  // Next storage: merged bytes land in the pre-swap bank; reset wins over everything
  always_comb begin
    for (int j = 0; j < NB; j++) begin
      mem_d[j] = mem_q[j];
    end
    for (int i = 0; i < NREGS; i++) begin
      mem_d[bank_off + MW'(i)] = nxt[i];
    end
    bank_d = (BANKS == 2) ? (bank_q ^ bank_swap) : 1'b0;
    if (rst) begin
      for (int j = 0; j < NB; j++) begin
        if (j % NREGS == 2*SP_PAIR) begin
          mem_d[j] = SP_RST[2*DW-1:DW];
        end else if (j % NREGS == 2*SP_PAIR + 1) begin
          mem_d[j] = SP_RST[DW-1:0];
        end else begin
          mem_d[j] = '0;
        end
      end
      bank_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    mem_q  <= mem_d;
    bank_q <= bank_d;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp in banked/bypass and single/stored configurations
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [5:0]  rd_sel;
  logic [1:0]  rdw_sel;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        wrw_en;
  logic [1:0]  wrw_sel;
  logic [15:0] wrw_data;
  logic [1:0]  idu_op;
  logic [1:0]  idu_sel;
  logic        bank_swap;

  logic [15:0] rd_a, rdw_a, hl_a, sp_a, idu_a;
  logic [15:0] rd_b, rdw_b, hl_b, sp_b, idu_b;
  logic        bank_a, bank_b;

  // dut_a: two banks, bypass on; dut_b: one bank, bypass off
  regfile_mp #(.DW(8), .NREGS(8), .NRD(2), .BANKS(2), .BYPASS(1), .SP_RST(16'hFFFE)) dut_a (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_a), .rdw_sel(rdw_sel), .rdw_data(rdw_a),
    .hl(hl_a), .sp(sp_a), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wrw_en(wrw_en),
    .wrw_sel(wrw_sel), .wrw_data(wrw_data), .idu_op(idu_op), .idu_sel(idu_sel), .idu_out(idu_a),
    .bank_swap(bank_swap), .bank(bank_a)
  );

  regfile_mp #(.DW(8), .NREGS(8), .NRD(2), .BANKS(1), .BYPASS(0), .SP_RST(16'hFFFE)) dut_b (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_data(rd_b), .rdw_sel(rdw_sel), .rdw_data(rdw_b),
    .hl(hl_b), .sp(sp_b), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wrw_en(wrw_en),
    .wrw_sel(wrw_sel), .wrw_data(wrw_data), .idu_op(idu_op), .idu_sel(idu_sel), .idu_out(idu_b),
    .bank_swap(bank_swap), .bank(bank_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0]  rd0;
    logic [7:0]  rd1;
    logic [15:0] rdw;
    logic [15:0] hl;
    logic [15:0] sp;
    logic [15:0] idu;
    logic        bank;
  } dexp_t;

  typedef struct packed {
    logic  check;
    dexp_t a;
    dexp_t b;
  } sb_t;

  sb_t        exp_q [$];
  int         total = 0;
  int         bad   = 0;

  // Reference model: m[dut][bank][reg]
  logic [7:0] m  [2][2][8];
  int         bank_m [2];
  logic [7:0] nx [2][8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current inputs and the bytes each register will hold after the edge
  task automatic eval_dut(input int d, output dexp_t e);
    logic [7:0]  cur [8];
    logic [7:0]  nv  [8];
    logic [7:0]  vw  [8];
    logic [15:0] pv, iv;
    int b, s, p, r;
    b = bank_m[d];
    for (int i = 0; i < 8; i++) cur[i] = m[d][b][i];
    s  = int'(idu_sel);
    pv = {cur[2*s], cur[2*s+1]};
    if (idu_op == 2'b01)      iv = pv + 16'd1;
    else if (idu_op == 2'b10) iv = pv - 16'd1;
    else                      iv = pv;
    for (int i = 0; i < 8; i++) nv[i] = cur[i];
    if (idu_op == 2'b01 || idu_op == 2'b10) begin
      nv[2*s]   = iv[15:8];
      nv[2*s+1] = iv[7:0];
    end
    if (wrw_en) begin
      p = int'(wrw_sel);
      nv[2*p]   = wrw_data[15:8];
      nv[2*p+1] = wrw_data[7:0];
    end
    if (wr_en) nv[wr_sel] = wr_data;
    for (int i = 0; i < 8; i++) vw[i] = (d == 0) ? nv[i] : cur[i];
    r      = int'(rdw_sel);
    e.rd0  = vw[rd_sel[2:0]];
    e.rd1  = vw[rd_sel[5:3]];
    e.rdw  = {vw[2*r], vw[2*r+1]};
    e.hl   = {vw[4], vw[5]};
    e.sp   = {vw[6], vw[7]};
    e.idu  = iv;
    e.bank = (b != 0);
    for (int i = 0; i < 8; i++) nx[d][i] = nv[i];
  endtask

  task automatic commit(input int d, input logic r, input logic sw);
    if (r) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 8; i++)
          m[d][b][i] = (i == 6) ? 8'hFF : (i == 7) ? 8'hFE : 8'h00;
      bank_m[d] = 0;
    end else begin
      for (int i = 0; i < 8; i++) m[d][bank_m[d]][i] = nx[d][i];
      if (d == 0 && sw) bank_m[d] = 1 - bank_m[d];
    end
  endtask

  // One clock of stimulus: push expectations, cross the edge, advance the model
  task automatic step();
    sb_t  s;
    logic r, sw;
    s.check = !rst;
    eval_dut(0, s.a);
    eval_dut(1, s.b);
    exp_q.push_back(s);
    r  = rst;
    sw = bank_swap;
    @(posedge clk);
    commit(0, r, sw);
    commit(1, r, sw);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; wrw_en = 1'b0; idu_op = 2'b00; bank_swap = 1'b0;
    wr_sel = '0; wr_data = '0; wrw_sel = '0; wrw_data = '0; idu_sel = '0;
    rd_sel = '0; rdw_sel = '0;
  endtask

  // Monitor: every cycle the DUTs present outputs; compare against the queued expectation
  always @(negedge clk) begin
    sb_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.check) begin
        chk("a_rd0", {8'h0, rd_a[7:0]},  {8'h0, e.a.rd0});
        chk("a_rd1", {8'h0, rd_a[15:8]}, {8'h0, e.a.rd1});
        chk("a_rdw", rdw_a, e.a.rdw);
        chk("a_hl",  hl_a,  e.a.hl);
        chk("a_sp",  sp_a,  e.a.sp);
        chk("a_idu", idu_a, e.a.idu);
        chk("a_bank", {15'h0, bank_a}, {15'h0, e.a.bank});
        chk("b_rd0", {8'h0, rd_b[7:0]},  {8'h0, e.b.rd0});
        chk("b_rd1", {8'h0, rd_b[15:8]}, {8'h0, e.b.rd1});
        chk("b_rdw", rdw_b, e.b.rdw);
        chk("b_hl",  hl_b,  e.b.hl);
        chk("b_sp",  sp_b,  e.b.sp);
        chk("b_idu", idu_b, e.b.idu);
        chk("b_bank", {15'h0, bank_b}, {15'h0, e.b.bank});
      end
    end
  end

  initial begin
    idle();
    bank_m[0] = 0;
    bank_m[1] = 0;
    @(posedge clk);
    #1;
    // Reset, second cycle with concurrent writes that must be discarded
    rst = 1'b1;
    step();
    wr_en = 1'b1; wr_sel = 3'd4; wr_data = 8'h77;
    wrw_en = 1'b1; wrw_sel = 2'd3; wrw_data = 16'h1234;
    idu_op = 2'b01; idu_sel = 2'd0; bank_swap = 1'b1;
    step();
    idle();
    #1;
    chk("t1_sp_a", sp_a, 16'hFFFE);
    chk("t1_sp_b", sp_b, 16'hFFFE);
    chk("t1_bank", {15'h0, bank_a}, 16'h0);
    chk("t1_hl_a", hl_a, 16'h0000);
    step();
    step();
    chk("t1_hold", sp_b, 16'hFFFE);

    // Pair write then two increments, then decrement of SP from 0000
    wrw_en = 1'b1; wrw_sel = 2'd2; wrw_data = 16'h1234;
    step();
    idle();
    idu_op = 2'b01; idu_sel = 2'd2;
    #1;
    chk("t2_idu1", idu_a, 16'h1235);
    step();
    #1;
    chk("t2_idu2", idu_b, 16'h1236);
    step();
    idle();
    #1;
    chk("t2_hl", hl_b, 16'h1236);
    wrw_en = 1'b1; wrw_sel = 2'd3; wrw_data = 16'h0000;
    step();
    idle();
    idu_op = 2'b10; idu_sel = 2'd3;
    step();
    idle();
    #1;
    chk("t2_sp_wrap", sp_b, 16'hFFFF);

    // Same-cycle pair write, byte write and IDU on HL
    wrw_en = 1'b1; wrw_sel = 2'd2; wrw_data = 16'hABCD;
    wr_en = 1'b1; wr_sel = 3'd5; wr_data = 8'h55;
    idu_op = 2'b01; idu_sel = 2'd2;
    #1;
    chk("t3_hl_byp", hl_a, 16'hAB55);
    step();
    idle();
    #1;
    chk("t3_hl_b", hl_b, 16'hAB55);

    // Bypass vs stored read of B
    wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'h3C;
    rd_sel = {3'd5, 3'd0};
    #1;
    chk("t4_byp", {8'h0, rd_a[7:0]}, 16'h003C);
    chk("t4_nobyp", {8'h0, rd_b[7:0]}, 16'h0000);
    step();
    idle();
    rd_sel = {3'd5, 3'd0};
    #1;
    chk("t4_next", {8'h0, rd_b[7:0]}, 16'h003C);

    // Banks: DE per bank, swap-cycle write lands in the old bank
    wrw_en = 1'b1; wrw_sel = 2'd1; wrw_data = 16'h1111;
    step();
    idle(); bank_swap = 1'b1;
    step();
    idle(); wrw_en = 1'b1; wrw_sel = 2'd1; wrw_data = 16'h2222;
    step();
    idle(); rdw_sel = 2'd1;
    #1;
    chk("t5_bank1", rdw_a, 16'h2222);
    chk("t5_bankidx", {15'h0, bank_a}, 16'h0001);
    bank_swap = 1'b1;
    step();
    idle(); rdw_sel = 2'd1;
    #1;
    chk("t5_bank0", rdw_a, 16'h1111);
    bank_swap = 1'b1; wrw_en = 1'b1; wrw_sel = 2'd1; wrw_data = 16'h3333;
    step();
    idle(); rdw_sel = 2'd1;
    #1;
    chk("t5_swapwr_new", rdw_a, 16'h2222);
    chk("t5_single", rdw_b, 16'h3333);
    bank_swap = 1'b1;
    step();
    idle(); rdw_sel = 2'd1;
    #1;
    chk("t5_swapwr_old", rdw_a, 16'h3333);

    // Reset concurrent with every write source and swap
    rst = 1'b1; bank_swap = 1'b1;
    wr_en = 1'b1; wr_sel = 3'd5; wr_data = 8'h99;
    wrw_en = 1'b1; wrw_sel = 2'd2; wrw_data = 16'hBEEF;
    idu_op = 2'b10; idu_sel = 2'd3;
    step();
    idle(); rdw_sel = 2'd1;
    #1;
    chk("t6_sp", sp_a, 16'hFFFE);
    chk("t6_hl", hl_a, 16'h0000);
    chk("t6_de", rdw_a, 16'h0000);
    chk("t6_bank", {15'h0, bank_a}, 16'h0000);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      rd_sel    = 6'($urandom);
      rdw_sel   = 2'($urandom);
      wr_en     = 1'($urandom);
      wr_sel    = 3'($urandom);
      wr_data   = 8'($urandom);
      wrw_en    = 1'($urandom);
      wrw_sel   = 2'($urandom);
      wrw_data  = (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      idu_op    = 2'($urandom);
      idu_sel   = 2'($urandom);
      bank_swap = ($urandom_range(0, 5) == 0);
      step();
    end

    idle();
    step();
    repeat (3) @(negedge clk);
    chk("sb_drain", 16'(exp_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
